// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter with bounded bus lock in front of a single-ported
// data memory; one access per cycle, read data returned two cycles after grant.
module dm_arbiter #(
    parameter int unsigned AW       = 8,
    parameter int unsigned DW       = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          r0_req,
    input  logic          r0_we,
    input  logic          r0_lock,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_rdata,

    input  logic          r1_req,
    input  logic          r1_we,
    input  logic          r1_lock,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_rdata,

    output logic          dm_w_en,
    output logic          dm_r_en,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_w_data,
    input  logic [DW-1:0] dm_r_data
);

    localparam int unsigned   HW         = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(MAX_HOLD);
    localparam bit            PREEMPT_EN = (MAX_HOLD != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    typedef struct packed {
        logic          we;
        logic          lock;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } acc_t;

    state_t        state;
    state_t        state_nx;
    logic          last_grant;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_nx;
    logic          rd_pend;
    logic          rd_tag;

    acc_t          acc0_c;
    acc_t          acc1_c;
    acc_t          sel_c;
    logic          gnt_c;
    logic          gnt_id_c;
    logic          locked_c;
    logic          own_id_c;
    logic          own_req_c;
    logic          oth_req_c;
    logic          preempt_c;

    assign acc0_c = {r0_we, r0_lock, r0_addr, r0_wdata};
    assign acc1_c = {r1_we, r1_lock, r1_addr, r1_wdata};
    assign sel_c  = gnt_id_c ? acc1_c : acc0_c;

    assign r0_gnt = gnt_c & ~gnt_id_c;
    assign r1_gnt = gnt_c &  gnt_id_c;

    // Lock owner view; preemption fires once the owner has used its hold budget.
    always_comb begin
        own_id_c  = (state == LOCK1);
        own_req_c = own_id_c ? r1_req : r0_req;
        oth_req_c = own_id_c ? r0_req : r1_req;
        preempt_c = PREEMPT_EN && (hold_cnt == HOLD_MAX) && oth_req_c;
    end

    // Grant decision: at most one requester per cycle, suppressed during reset.
    always_comb begin
        gnt_c    = 1'b0;
        gnt_id_c = 1'b0;
        locked_c = 1'b0;
        if (state != IDLE) begin
            if (own_req_c && !preempt_c) begin
                gnt_c    = 1'b1;
                gnt_id_c = own_id_c;
                locked_c = 1'b1;
            end else if (oth_req_c) begin
                gnt_c    = 1'b1;
                gnt_id_c = ~own_id_c;
            end
        end else if (r0_req && r1_req) begin
            gnt_c    = 1'b1;
            gnt_id_c = ~last_grant;
        end else if (r0_req) begin
            gnt_c    = 1'b1;
            gnt_id_c = 1'b0;
        end else if (r1_req) begin
            gnt_c    = 1'b1;
            gnt_id_c = 1'b1;
        end
        if (!rst_n) begin
            gnt_c = 1'b0;
        end
    end

    // Next lock state: any grant without lock, or no grant at all, returns to IDLE.
    always_comb begin
        state_nx = IDLE;
        hold_nx  = '0;
        if (gnt_c && sel_c.lock) begin
            state_nx = gnt_id_c ? LOCK1 : LOCK0;
            if (locked_c) begin
                hold_nx = (hold_cnt < HOLD_MAX) ? hold_cnt + HW'(1) : hold_cnt;
            end else begin
                hold_nx = HW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            hold_cnt   <= '0;
            rd_pend    <= 1'b0;
            rd_tag     <= 1'b0;
            dm_w_en    <= 1'b0;
            dm_r_en    <= 1'b0;
            dm_addr    <= '0;
            dm_w_data  <= '0;
            r0_rvalid  <= 1'b0;
            r1_rvalid  <= 1'b0;
            r0_rdata   <= '0;
            r1_rdata   <= '0;
        end else begin
            state    <= state_nx;
            hold_cnt <= hold_nx;

            // Stage 1: launch the granted access onto the memory port.
            if (gnt_c) begin
                last_grant <= gnt_id_c;
                dm_w_en    <= sel_c.we;
                dm_r_en    <= ~sel_c.we;
                dm_addr    <= sel_c.addr;
                dm_w_data  <= sel_c.wdata;
                rd_pend    <= ~sel_c.we;
                rd_tag     <= gnt_id_c;
            end else begin
                dm_w_en <= 1'b0;
                dm_r_en <= 1'b0;
                rd_pend <= 1'b0;
            end

            // Stage 2: route the memory read data back to its issuer.
            r0_rvalid <= rd_pend && !rd_tag;
            r1_rvalid <= rd_pend &&  rd_tag;
            if (rd_pend && !rd_tag) begin
                r0_rdata <= dm_r_data;
            end
            if (rd_pend && rd_tag) begin
                r1_rdata <= dm_r_data;
            end
        end
    end

endmodule
